// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: load/store/branch type codes and the
// handshake FSM state.
package mem_stage_pkg;

    typedef enum logic [2:0] {
        LD_LB  = 3'd0,
        LD_LBU = 3'd1,
        LD_LH  = 3'd2,
        LD_LHU = 3'd3,
        LD_LW  = 3'd4
    } load_type_e;

    typedef enum logic [1:0] {
        ST_SB = 2'd0,
        ST_SH = 2'd1,
        ST_SW = 2'd2
    } store_type_e;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BGEZ = 3'd1,
        BR_BGTZ = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BLTZ = 3'd4,
        BR_BNE  = 3'd5
    } branch_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables and replicated write data,
// plus sign/zero extension of returned load data.
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  byte_off,
    input  logic [1:0]  store_type,
    input  logic [31:0] store_data,
    input  logic [2:0]  load_type,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Replicating the store data means the memory only needs the enables.
    always_comb begin
        be    = 4'b0000;
        wdata = store_data;
        case (store_type)
            ST_SB: begin
                be    = 4'b0001 << byte_off;
                wdata = {4{store_data[7:0]}};
            end
            ST_SH: begin
                be    = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            ST_SW:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        load_byte = rdata[{byte_off, 3'b000} +: 8];
        load_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (load_type)
            LD_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            LD_LBU:  load_data = {24'h000000, load_byte};
            LD_LH:   load_data = {{16{load_half[15]}}, load_half};
            LD_LHU:  load_data = {16'h0000, load_half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage driving a req/gnt/rvalid data memory and stalling EX while busy.
// Optional access timeout enabled by defining DMEM_TIMEOUT_EN.
module mem_stage_hs
    import mem_stage_pkg::*;
#(
    parameter int DMEM_AW = 6
`ifdef DMEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [31:0]        ex_alu_out,
    input  logic [31:0]        ex_reg_b_data,
    input  logic [4:0]         ex_rd,
    input  logic               ex_reg_write,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic [2:0]         ex_load_type,
    input  logic [1:0]         ex_store_type,
    input  logic               ex_branch,
    input  logic [2:0]         ex_branch_type,
    input  logic [5:0]         ex_cmp_flags,
    input  logic               ex_jump,
    output logic               branch_taken,
    output logic               jump_taken,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [3:0]         dmem_be,
    output logic [31:0]        dmem_wdata,
    input  logic               dmem_gnt,
    input  logic               dmem_rvalid,
    input  logic [31:0]        dmem_rdata,
    output logic               mem_wb_valid,
    output logic               mem_wb_reg_write,
    output logic [4:0]         mem_wb_rd,
    output logic [31:0]        mem_wb_data,
    output logic               mem_wb_err
);

    state_e      state;
    logic        is_load;
    logic        is_store;
    logic        mem_op;
    logic [3:0]  lane_be;
    logic [31:0] load_data;
    logic [7:0]  flags_ext;

    assign is_load  = ex_valid & ex_mem_read;
    assign is_store = ex_valid & ex_mem_write & ~ex_mem_read;
    assign mem_op   = is_load | is_store;

    assign flags_ext    = {2'b00, ex_cmp_flags};
    assign branch_taken = ex_valid & ex_branch & (ex_branch_type <= BR_BNE) & flags_ext[ex_branch_type];
    assign jump_taken   = ex_valid & ex_jump;

    // Reset gates the request directly so it drops without waiting for a clock.
    assign dmem_req   = ~rst & (state == IDLE) & mem_op;
    assign dmem_we    = is_store;
    assign dmem_addr  = ex_alu_out[DMEM_AW+1:2];
    assign dmem_be    = is_store ? lane_be : 4'b0000;

    lsu_align u_lsu_align (
        .byte_off   (ex_alu_out[1:0]),
        .store_type (ex_store_type),
        .store_data (ex_reg_b_data),
        .load_type  (ex_load_type),
        .rdata      (dmem_rdata),
        .be         (lane_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data)
    );

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;
    logic             timeout;
`endif

    always_comb begin
        ex_ready = 1'b1;
`ifdef DMEM_TIMEOUT_EN
        waiting  = 1'b0;
`endif
        if (state == RESP) begin
            ex_ready = dmem_rvalid;
`ifdef DMEM_TIMEOUT_EN
            waiting  = ~dmem_rvalid;
`endif
        end else if (mem_op) begin
            ex_ready = is_store & dmem_gnt;
`ifdef DMEM_TIMEOUT_EN
            waiting  = ~dmem_gnt;
`endif
        end
`ifdef DMEM_TIMEOUT_EN
        // The current cycle is the TIMEOUT_CYC-th one spent waiting.
        timeout = waiting & (wait_cnt == CNT_LAST);
        if (timeout) begin
            ex_ready = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            mem_wb_valid     <= 1'b0;
            mem_wb_reg_write <= 1'b0;
            mem_wb_rd        <= 5'd0;
            mem_wb_data      <= 32'd0;
`ifdef DMEM_TIMEOUT_EN
            mem_wb_err       <= 1'b0;
            wait_cnt         <= '0;
`endif
        end else begin
            if (state == IDLE) begin
                if (is_load && dmem_gnt) begin
                    state <= RESP;
                end
            end else if (ex_ready) begin
                state <= IDLE;
            end

            if (ex_ready) begin
                mem_wb_valid     <= ex_valid;
                mem_wb_rd        <= ex_rd;
                mem_wb_reg_write <= ex_valid & ex_reg_write;
                mem_wb_data      <= is_load ? load_data : ex_alu_out;
            end else begin
                mem_wb_valid     <= 1'b0;
                mem_wb_reg_write <= 1'b0;
            end

`ifdef DMEM_TIMEOUT_EN
            mem_wb_err <= timeout;
            if (timeout) begin
                mem_wb_data      <= 32'd0;
                mem_wb_reg_write <= 1'b0;
            end
            if (ex_ready) begin
                wait_cnt <= '0;
            end else if (waiting && wait_cnt != CNT_LAST) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
`endif
        end
    end

`ifndef DMEM_TIMEOUT_EN
    assign mem_wb_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_hs.sv
// Randomized bench for mem_stage_hs against a byte-level memory reference model.
module tb_mem_stage_hs;

    localparam int DMEM_AW = 6;

    typedef struct {
        logic        valid;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        jump;
        logic [2:0]  load_type;
        logic [1:0]  store_type;
        logic [2:0]  branch_type;
        logic [5:0]  flags;
        logic [31:0] alu;
        logic [31:0] bdata;
        logic [4:0]  rd;
        int          g;
        int          k;
    } instr_t;

    logic               clk;
    logic               rst;
    logic               ex_valid;
    logic               ex_ready;
    logic [31:0]        ex_alu_out;
    logic [31:0]        ex_reg_b_data;
    logic [4:0]         ex_rd;
    logic               ex_reg_write;
    logic               ex_mem_read;
    logic               ex_mem_write;
    logic [2:0]         ex_load_type;
    logic [1:0]         ex_store_type;
    logic               ex_branch;
    logic [2:0]         ex_branch_type;
    logic [5:0]         ex_cmp_flags;
    logic               ex_jump;
    logic               branch_taken;
    logic               jump_taken;
    logic               dmem_req;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [3:0]         dmem_be;
    logic [31:0]        dmem_wdata;
    logic               dmem_gnt;
    logic               dmem_rvalid;
    logic [31:0]        dmem_rdata;
    logic               mem_wb_valid;
    logic               mem_wb_reg_write;
    logic [4:0]         mem_wb_rd;
    logic [31:0]        mem_wb_data;
    logic               mem_wb_err;

    int          checks;
    int          failures;
    logic [7:0]  ref_bytes [0:255];
    logic [31:0] bus_mem [0:63];

    mem_stage_hs #(.DMEM_AW(DMEM_AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_alu_out       (ex_alu_out),
        .ex_reg_b_data    (ex_reg_b_data),
        .ex_rd            (ex_rd),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_load_type     (ex_load_type),
        .ex_store_type    (ex_store_type),
        .ex_branch        (ex_branch),
        .ex_branch_type   (ex_branch_type),
        .ex_cmp_flags     (ex_cmp_flags),
        .ex_jump          (ex_jump),
        .branch_taken     (branch_taken),
        .jump_taken       (jump_taken),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_gnt         (dmem_gnt),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .mem_wb_valid     (mem_wb_valid),
        .mem_wb_reg_write (mem_wb_reg_write),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_data      (mem_wb_data),
        .mem_wb_err       (mem_wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic int storeSize(input logic [1:0] st);
        return (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : 4;
    endfunction

    function automatic int loadSize(input logic [2:0] lt);
        return (lt <= 3'd1) ? 1 : (lt <= 3'd3) ? 2 : 4;
    endfunction

    function automatic logic [31:0] refLoad(input int a, input logic [2:0] lt);
        int          size;
        int          base;
        logic [31:0] v;
        size = loadSize(lt);
        base = a - (a % size);
        v    = 32'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_bytes[base + i];
        if (lt == 3'd0 && v[7])  v[31:8]  = '1;
        if (lt == 3'd2 && v[15]) v[31:16] = '1;
        return v;
    endfunction

    function automatic logic [3:0] refBe(input int a, input int size);
        int         base;
        int         word;
        logic [3:0] be;
        base = a - (a % size);
        word = a - (a % 4);
        for (int i = 0; i < 4; i++) be[i] = (word + i >= base) && (word + i < base + size);
        return be;
    endfunction

    function automatic logic [31:0] refWdata(input logic [31:0] d, input int size);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % size) +: 8];
        return w;
    endfunction

    function automatic instr_t memOp(input logic load, input logic [2:0] ty, input logic [31:0] alu,
                                     input logic [31:0] bdata, input int g, input int k);
        instr_t t;
        t = '{default: 0};
        t.valid      = 1'b1;
        t.mem_read   = load;
        t.mem_write  = ~load;
        t.reg_write  = load;
        t.load_type  = ty;
        t.store_type = ty[1:0];
        t.alu        = alu;
        t.bdata      = bdata;
        t.rd         = 5'd7;
        t.g          = g;
        t.k          = k;
        return t;
    endfunction

    task automatic driveEx(input instr_t t);
        ex_valid       = t.valid;
        ex_mem_read    = t.mem_read;
        ex_mem_write   = t.mem_write;
        ex_reg_write   = t.reg_write;
        ex_branch      = t.branch;
        ex_jump        = t.jump;
        ex_load_type   = t.load_type;
        ex_store_type  = t.store_type;
        ex_branch_type = t.branch_type;
        ex_cmp_flags   = t.flags;
        ex_alu_out     = t.alu;
        ex_reg_b_data  = t.bdata;
        ex_rd          = t.rd;
    endtask

    // One instruction: gnt arrives t.g cycles after the request, rvalid t.k cycles after gnt.
    task automatic applyStimulus(input instr_t t);
        logic        is_load;
        logic        is_store;
        logic        mem_op;
        logic        exp_br;
        int          a;
        int          size;
        int          last;
        logic [31:0] exp_data;
        is_load  = t.valid && t.mem_read;
        is_store = t.valid && t.mem_write && !t.mem_read;
        mem_op   = is_load || is_store;
        a        = int'(t.alu[7:0]);
        size     = storeSize(t.store_type);
        last     = !mem_op ? 0 : is_store ? t.g : t.g + t.k;
        exp_data = is_load ? refLoad(a, t.load_type) : t.alu;
        exp_br   = t.valid && t.branch && (t.branch_type < 3'd6) && (((t.flags >> t.branch_type) & 6'd1) != 6'd0);
        @(negedge clk);
        driveEx(t);
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge clk);
            if (mem_op && c <= t.g) dmem_gnt = (c == t.g);
            else                    dmem_gnt = 1'($urandom_range(0, 1));
            if (is_load && c > t.g) dmem_rvalid = (c == t.g + t.k);
            else                    dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata = (is_load && c == t.g + t.k) ? bus_mem[t.alu[7:2]] : $urandom;
            #1;
            if (c == 0) begin
                checkOutput("branch_taken", branch_taken, exp_br);
                checkOutput("jump_taken", jump_taken, t.valid && t.jump);
            end
            checkOutput("dmem_req", dmem_req, mem_op && c <= t.g);
            checkOutput("ex_ready", ex_ready, c == last);
            if (mem_op && c <= t.g) begin
                checkOutput("dmem_addr", dmem_addr, t.alu[7:2]);
                checkOutput("dmem_we", dmem_we, is_store);
                if (is_store) begin
                    checkOutput("dmem_be", dmem_be, refBe(a, size));
                    checkOutput("dmem_wdata", dmem_wdata, refWdata(t.bdata, size));
                end
            end
            if (is_store && c == t.g) begin
                for (int i = 0; i < 4; i++)
                    if (dmem_be[i]) bus_mem[t.alu[7:2]][8*i +: 8] = dmem_wdata[8*i +: 8];
            end
            @(posedge clk);
            #1;
            if (c == last) begin
                checkOutput("wb_valid", mem_wb_valid, t.valid);
                checkOutput("wb_reg_write", mem_wb_reg_write, t.valid && t.reg_write);
                checkOutput("wb_rd", mem_wb_rd, t.rd);
                checkOutput("wb_data", mem_wb_data, exp_data);
                checkOutput("wb_err", mem_wb_err, 1'b0);
            end else begin
                checkOutput("bubble_valid", mem_wb_valid, 1'b0);
                checkOutput("bubble_reg_write", mem_wb_reg_write, 1'b0);
            end
        end
        if (is_store) begin
            for (int i = 0; i < size; i++) ref_bytes[a - (a % size) + i] = t.bdata[8*i +: 8];
        end
    endtask

    initial begin
        instr_t t;
        int     r;
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
        t = '{default: 0};
        driveEx(t);
        for (int w = 0; w < 64; w++) begin
            bus_mem[w] = $urandom;
            for (int i = 0; i < 4; i++) ref_bytes[4*w + i] = bus_mem[w][8*i +: 8];
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_wb_valid", mem_wb_valid, 1'b0);
        checkOutput("reset_wb_reg_write", mem_wb_reg_write, 1'b0);
        checkOutput("reset_wb_rd", mem_wb_rd, 5'd0);
        checkOutput("reset_wb_data", mem_wb_data, 32'd0);
        checkOutput("reset_wb_err", mem_wb_err, 1'b0);
        checkOutput("reset_req", dmem_req, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(memOp(1'b0, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0));
        applyStimulus(memOp(1'b0, 3'd0, 32'h0000_0013, 32'h0000_00AB, 0, 0));
        applyStimulus(memOp(1'b0, 3'd0, 32'h0000_0013, 32'h0000_0080, 0, 0));
        applyStimulus(memOp(1'b1, 3'd0, 32'h0000_0013, 32'd0, 0, 1));
        applyStimulus(memOp(1'b0, 3'd2, 32'h0000_0010, 32'hBEEF_1234, 1, 0));
        applyStimulus(memOp(1'b1, 3'd3, 32'h0000_0012, 32'd0, 2, 3));
        applyStimulus(memOp(1'b1, 3'd2, 32'h0000_0011, 32'd0, 0, 2));

        t = '{default: 0};
        t.valid = 1'b1; t.branch = 1'b1; t.branch_type = 3'd5; t.flags = 6'b100000;
        t.alu = 32'h1234_5678; t.rd = 5'd3; t.reg_write = 1'b1;
        applyStimulus(t);
        t.branch_type = 3'd6; t.flags = 6'b111111; t.jump = 1'b1;
        applyStimulus(t);

        // Reset lands while a load waits for rvalid; the late rvalid must not reach WB.
        @(negedge clk);
        driveEx(memOp(1'b1, 3'd4, 32'h0000_0020, 32'd0, 0, 1));
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        checkOutput("resp_ready", ex_ready, 1'b0);
        checkOutput("resp_req", dmem_req, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("rst_req", dmem_req, 1'b0);
        checkOutput("rst_wb_data", mem_wb_data, 32'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata  = $urandom;
        #1;
        checkOutput("late_ready", ex_ready, 1'b1);
        checkOutput("late_req", dmem_req, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("late_wb_valid", mem_wb_valid, 1'b0);
        checkOutput("late_wb_reg_write", mem_wb_reg_write, 1'b0);
        checkOutput("late_wb_data", mem_wb_data, 32'h0000_0020);
        dmem_rvalid = 1'b0;

        for (int n = 0; n < 300; n++) begin
            t = '{default: 0};
            r = $urandom_range(0, 9);
            t.valid       = ($urandom_range(0, 9) != 0);
            t.mem_read    = (r < 3);
            t.mem_write   = (r >= 3 && r < 6);
            t.load_type   = 3'($urandom_range(0, 4));
            t.store_type  = 2'($urandom_range(0, 2));
            t.alu         = $urandom;
            t.bdata       = $urandom;
            t.rd          = 5'($urandom);
            t.reg_write   = 1'($urandom);
            t.branch      = 1'($urandom);
            t.branch_type = 3'($urandom);
            t.flags       = 6'($urandom);
            t.jump        = 1'($urandom);
            t.g           = $urandom_range(0, 3);
            t.k           = $urandom_range(1, 3);
            applyStimulus(t);
        end

`ifdef DMEM_TIMEOUT_EN
        // Grant never arrives: the 16th waiting cycle releases EX with an error.
        @(negedge clk);
        driveEx(memOp(1'b1, 3'd4, 32'h0000_0004, 32'd0, 0, 1));
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checkOutput("to_ready", ex_ready, c == 15);
            @(posedge clk);
            #1;
            checkOutput("to_err", mem_wb_err, c == 15);
            if (c == 15) begin
                checkOutput("to_wb_valid", mem_wb_valid, 1'b1);
                checkOutput("to_wb_reg_write", mem_wb_reg_write, 1'b0);
                checkOutput("to_wb_data", mem_wb_data, 32'd0);
            end
        end
        @(negedge clk);
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("to_err_pulse", mem_wb_err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
